branch_predictor: RTL

Dynamic conditional-branch predictor that controls the fetch stage's prediction choice, replacing the fixed always-taken policy. It keeps a table of 2-bit saturating counters and predicts each decoded conditional branch. It records every issued prediction in a small in-flight queue. When the executor resolves the oldest branch, the block flags a mispredict to fetch and trains the table.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/branch_predictor_if.sv | 30 +++
 rtl/bp_inflight_fifo.sv | 63 ++++++
 rtl/branch_predictor.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the conditional-branch predictor:
// counter encodings, FSM states, in-flight entry, counter update.
package bp_pkg;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Widest table index an in-flight entry can carry.
    localparam int IDX_MAX = 16;

    typedef enum logic {
        INIT,
        RUN
    } bp_state_e;

    typedef struct packed {
        logic [IDX_MAX-1:0] index;
        logic               pred;
    } bp_entry_t;

    function automatic logic [1:0] sat_update(
        input logic [1:0] c,
        input logic       taken
    );
        if (taken)
            return (c == ST) ? ST : c + 2'd1;
        else
            return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Decoder/executor <-> predictor bundle.
// master: pred_valid/pred_pc/upd_valid/upd_taken out; predict_taken/mispredict in.
interface branch_predictor_if;

    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        predict_taken;
    logic        upd_valid;
    logic        upd_taken;
    logic        mispredict;

    modport master (
        output pred_valid,
        output pred_pc,
        output upd_valid,
        output upd_taken,
        input  predict_taken,
        input  mispredict
    );

    modport slave (
        input  pred_valid,
        input  pred_pc,
        input  upd_valid,
        input  upd_taken,
        output predict_taken,
        output mispredict
    );

endinterface

// File: rtl/bp_inflight_fifo.sv
// DEPTH-entry queue of unresolved predictions.
// Ports: i_clk, i_reset, i_push/i_din, i_pop, i_flush, o_head, o_full, o_empty.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_push,
    input  bp_entry_t i_din,
    input  logic      i_pop,
    input  logic      i_flush,
    output bp_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    bp_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_rd;
    logic [PW-1:0]     r_wr;
    logic [CW-1:0]     r_cnt;

    logic              w_do_pop;
    logic              w_do_push;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_head    = r_mem[r_rd];

    // A pop frees the slot, so a push into a full queue is fine then.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wr] <= i_din;
    end

    // Flush accompanies a popping head: the head and everything
    // younger leave together, so the queue simply empties.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_pop)
                r_rd <= wrap_inc(r_rd);
            if (w_do_push)
                r_wr <= wrap_inc(r_wr);
            r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch predictor with in-flight queue.
// Ports: i_clk, i_reset, bp_if (slave), o_ready, o_err, o_miss_cnt.
// Option macro BP_GHR_EN: XOR a global history register into the index.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         IDX_BITS   = 6,
    parameter logic [1:0] INIT_STATE = 2'b10,
    parameter int         DEPTH      = 2,
    parameter int         GHR_BITS   = 6
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    branch_predictor_if.slave         bp_if,
    output logic                      o_ready,
    output logic                      o_err,
    output logic [31:0]               o_miss_cnt
);

    localparam int N = 1 << IDX_BITS;

    if (GHR_BITS > IDX_BITS || IDX_BITS > IDX_MAX) begin : g_bad_cfg
        $error("branch_predictor: bad IDX_BITS/GHR_BITS");
    end

    bp_state_e            r_state;
    bp_state_e            w_state_nxt;
    logic [IDX_BITS-1:0]  r_ptr;
    logic [1:0]           r_table [N];
    logic                 r_err;
    logic [31:0]          r_miss;

    logic                 w_run;
    logic [IDX_BITS-1:0]  w_idx;
    logic [IDX_BITS-1:0]  w_hidx;
    logic                 w_pred;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_mis;
    logic                 w_full;
    logic                 w_empty;
    bp_entry_t            w_head;
    bp_entry_t            w_din;
    logic                 w_unused;

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= INIT;
        else
            r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            INIT: if (r_ptr == IDX_BITS'(N - 1)) w_state_nxt = RUN;
            RUN:  w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_run   = (r_state == RUN);
        o_ready = w_run;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_ptr <= '0;
        else if (r_state == INIT)
            r_ptr <= r_ptr + 1'b1;
    end

`ifdef BP_GHR_EN
    logic [GHR_BITS-1:0] r_ghr;

    // History is updated only from resolved outcomes.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_ghr <= '0;
        else if (w_pop)
            r_ghr <= (r_ghr << 1) | GHR_BITS'(bp_if.upd_taken);
    end

    assign w_idx = bp_if.pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr);
`else
    assign w_idx = bp_if.pred_pc[IDX_BITS+1:2];
`endif

    assign w_pred  = w_run ? r_table[w_idx][1] : 1'b1;
    assign w_hidx  = w_head.index[IDX_BITS-1:0];

    assign w_pop   = w_run && bp_if.upd_valid && !w_empty;
    assign w_mis   = w_pop && (w_head.pred ^ bp_if.upd_taken);
    // A push in the mispredict cycle is on the wrong path.
    assign w_push  = w_run && bp_if.pred_valid && !w_mis;

    assign w_din.index = IDX_MAX'(w_idx);
    assign w_din.pred  = w_pred;

    assign bp_if.predict_taken = w_pred;
    assign bp_if.mispredict    = w_mis;

    assign w_unused = ^{bp_if.pred_pc, w_head.index};

    bp_inflight_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .i_flush (w_mis),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Prediction reads the table combinationally before this write
    // lands, so a same-entry predict sees the old counter.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (r_state == INIT)
                r_table[r_ptr] <= INIT_STATE;
            else if (w_pop)
                r_table[w_hidx] <= sat_update(r_table[w_hidx],
                                              bp_if.upd_taken);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_err <= 1'b0;
        else if (w_run &&
                 ((bp_if.pred_valid && w_full && !w_pop) ||
                  (bp_if.upd_valid && w_empty)))
            r_err <= 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_miss <= '0;
        else if (w_mis)
            r_miss <= r_miss + 32'd1;
    end

    assign o_err      = r_err;
    assign o_miss_cnt = r_miss;

endmodule
